// File: rtl/systolic_2x2_engine.sv
// 2x2 output-stationary systolic matrix-multiply engine behind a 16-bit host bus.
// Host loads A/B stream buffers, programs K-1/R-1, starts a job and reads back 32-bit results.
module systolic_2x2_engine #(
  parameter int DW        = 16,
  parameter int IDEPTH_LG = 8,
  parameter int ODEPTH_LG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ren,
  input  logic [15:0]   ibus_radr,
  output logic [DW-1:0] ibus_rdata,
  input  logic          wen,
  input  logic [15:0]   ibus_wadr,
  input  logic [DW-1:0] ibus_wdata
);

  localparam int AW     = 2 * DW;
  localparam int IDEPTH = 1 << IDEPTH_LG;
  localparam int ODEPTH = 1 << ODEPTH_LG;

  localparam logic [6:0]  RG_A0  = 7'h20;
  localparam logic [6:0]  RG_A1  = 7'h21;
  localparam logic [6:0]  RG_B0  = 7'h22;
  localparam logic [6:0]  RG_B1  = 7'h23;
  localparam logic [6:0]  RG_O00 = 7'h40;
  localparam logic [6:0]  RG_O10 = 7'h41;
  localparam logic [6:0]  RG_O01 = 7'h42;
  localparam logic [6:0]  RG_O11 = 7'h43;
  localparam logic [15:0] AD_START = 16'hFFF0;
  localparam logic [15:0] AD_MAX   = 16'hFFF1;
  localparam logic [15:0] AD_RUN   = 16'hFFF2;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DW-1:0] max_cntr, run_cntr;
  logic [DW-1:0] k_cnt, r_cnt;
  logic [IDEPTH_LG-1:0] rd_adr;
  logic [1:0] drain_cnt;
  logic busy, feed, k_last, r_last, start_req;
  logic wr_a0, wr_a1, wr_b0, wr_b1;

  logic [DW-1:0] a0_mem [IDEPTH];
  logic [DW-1:0] a1_mem [IDEPTH];
  logic [DW-1:0] b0_mem [IDEPTH];
  logic [DW-1:0] b1_mem [IDEPTH];
  logic [AW-1:0] o00_mem [ODEPTH];
  logic [AW-1:0] o10_mem [ODEPTH];
  logic [AW-1:0] o01_mem [ODEPTH];
  logic [AW-1:0] o11_mem [ODEPTH];

  logic [DW-1:0] a0_p0, a1_p0, b0_p0, b1_p0;
  logic [DW-1:0] a0_p1, a1_p1, b0_p1, b1_p1;
  logic [DW-1:0] a1_p2, b1_p2;
  logic vld_p0, vld_p1, vld_p2;
  logic first_p0, first_p1, first_p2;
  logic last_p0, last_p1, last_p2;
  logic [ODEPTH_LG-1:0] radr_p0, radr_p1, radr_p2;

  logic [AW-1:0] acc00, acc01, acc10, acc11;
  logic [AW-1:0] sum00, sum01, sum10, sum11;
  logic [DW-1:0] rd_mux;

  // Unsigned multiply-accumulate; the accumulator wraps modulo 2^AW.
  function automatic logic [AW-1:0] mac(input logic clr, input logic [AW-1:0] acc,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [AW-1:0] prod;
    prod = AW'(a) * AW'(b);
    return (clr ? '0 : acc) + prod;
  endfunction

  function automatic logic [DW-1:0] half_sel(input logic [AW-1:0] word, input logic hi);
    return hi ? word[AW-1:DW] : word[DW-1:0];
  endfunction

  assign busy   = (state != IDLE);
  assign feed   = (state == FEED);
  assign k_last = (k_cnt == max_cntr);
  assign r_last = (r_cnt == run_cntr);

  always_comb begin
    start_req = wen && (ibus_wadr == AD_START) && ibus_wdata[0];
    wr_a0     = wen && !busy && (ibus_wadr[15:9] == RG_A0);
    wr_a1     = wen && !busy && (ibus_wadr[15:9] == RG_A1);
    wr_b0     = wen && !busy && (ibus_wadr[15:9] == RG_B0);
    wr_b1     = wen && !busy && (ibus_wadr[15:9] == RG_B1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req) state_nxt = FEED;
      FEED:    if (k_last && r_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd3) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_cntr  <= '0;
      run_cntr  <= '0;
      k_cnt     <= '0;
      r_cnt     <= '0;
      rd_adr    <= '0;
      drain_cnt <= '0;
    end else begin
      if (wen && !busy && ibus_wadr == AD_MAX) max_cntr <= ibus_wdata;
      if (wen && !busy && ibus_wadr == AD_RUN) run_cntr <= ibus_wdata;
      if (state == IDLE && start_req) begin
        k_cnt  <= '0;
        r_cnt  <= '0;
        rd_adr <= '0;
      end else if (feed) begin
        rd_adr <= rd_adr + 1'b1;
        if (k_last) begin
          k_cnt <= '0;
          r_cnt <= r_cnt + 1'b1;
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 2'd0;
    end
  end

  // Buffer RAMs: host write port, engine read port (p0 operand register)
  always_ff @(posedge clk) begin
    if (wr_a0) a0_mem[ibus_wadr[IDEPTH_LG-1:0]] <= ibus_wdata;
    if (wr_a1) a1_mem[ibus_wadr[IDEPTH_LG-1:0]] <= ibus_wdata;
    if (wr_b0) b0_mem[ibus_wadr[IDEPTH_LG-1:0]] <= ibus_wdata;
    if (wr_b1) b1_mem[ibus_wadr[IDEPTH_LG-1:0]] <= ibus_wdata;
    if (feed) begin
      a0_p0 <= a0_mem[rd_adr];
      a1_p0 <= a1_mem[rd_adr];
      b0_p0 <= b0_mem[rd_adr];
      b1_p0 <= b1_mem[rd_adr];
    end
  end

  // p0 -> p1 -> p2: control travels with the skewed operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0; first_p0 <= 1'b0; last_p0 <= 1'b0; radr_p0 <= '0;
      vld_p1 <= 1'b0; first_p1 <= 1'b0; last_p1 <= 1'b0; radr_p1 <= '0;
      vld_p2 <= 1'b0; first_p2 <= 1'b0; last_p2 <= 1'b0; radr_p2 <= '0;
      a0_p1 <= '0; a1_p1 <= '0; b0_p1 <= '0; b1_p1 <= '0;
      a1_p2 <= '0; b1_p2 <= '0;
    end else begin
      vld_p0   <= feed;
      first_p0 <= (k_cnt == '0);
      last_p0  <= k_last;
      radr_p0  <= r_cnt[ODEPTH_LG-1:0];
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      radr_p1  <= radr_p0;
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      radr_p2  <= radr_p1;
      a0_p1    <= a0_p0;
      a1_p1    <= a1_p0;
      b0_p1    <= b0_p0;
      b1_p1    <= b1_p0;
      a1_p2    <= a1_p1;
      b1_p2    <= b1_p1;
    end
  end

  always_comb begin
    sum00 = mac(first_p0, acc00, a0_p0, b0_p0);
    sum01 = mac(first_p1, acc01, a0_p1, b1_p1);
    sum10 = mac(first_p1, acc10, a1_p1, b0_p1);
    sum11 = mac(first_p2, acc11, a1_p2, b1_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc00 <= '0;
      acc01 <= '0;
      acc10 <= '0;
      acc11 <= '0;
    end else begin
      if (vld_p0) acc00 <= sum00;
      if (vld_p1) acc01 <= sum01;
      if (vld_p1) acc10 <= sum10;
      if (vld_p2) acc11 <= sum11;
    end
  end

  // Result writeback on the last term of each run, at each PE's own stage
  always_ff @(posedge clk) begin
    if (vld_p0 && last_p0) o00_mem[radr_p0] <= sum00;
    if (vld_p1 && last_p1) o01_mem[radr_p1] <= sum01;
    if (vld_p1 && last_p1) o10_mem[radr_p1] <= sum10;
    if (vld_p2 && last_p2) o11_mem[radr_p2] <= sum11;
  end

  always_comb begin
    rd_mux = '0;
    case (ibus_radr[15:9])
      RG_A0:  rd_mux = a0_mem[ibus_radr[IDEPTH_LG-1:0]];
      RG_A1:  rd_mux = a1_mem[ibus_radr[IDEPTH_LG-1:0]];
      RG_B0:  rd_mux = b0_mem[ibus_radr[IDEPTH_LG-1:0]];
      RG_B1:  rd_mux = b1_mem[ibus_radr[IDEPTH_LG-1:0]];
      RG_O00: rd_mux = half_sel(o00_mem[ibus_radr[ODEPTH_LG-1:0]], ibus_radr[8]);
      RG_O10: rd_mux = half_sel(o10_mem[ibus_radr[ODEPTH_LG-1:0]], ibus_radr[8]);
      RG_O01: rd_mux = half_sel(o01_mem[ibus_radr[ODEPTH_LG-1:0]], ibus_radr[8]);
      RG_O11: rd_mux = half_sel(o11_mem[ibus_radr[ODEPTH_LG-1:0]], ibus_radr[8]);
      default: begin
        if (ibus_radr == AD_START)    rd_mux = {{(DW-1){1'b0}}, busy};
        else if (ibus_radr == AD_MAX) rd_mux = max_cntr;
        else if (ibus_radr == AD_RUN) rd_mux = run_cntr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ibus_rdata <= '0;
    else if (ren) ibus_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_systolic_2x2_engine.sv
// Randomized bench for systolic_2x2_engine, checked against a plain dot-product model
// of the A/B buffers and OBUF contents.
module tb_systolic_2x2_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] ibus_radr = '0;
  logic [15:0] ibus_wadr = '0;
  logic [15:0] ibus_wdata = '0;
  logic [15:0] ibus_rdata;

  int total = 0;
  int bad   = 0;

  logic [15:0] ma [2][256];
  logic [15:0] mb [2][256];
  logic [31:0] mo [4][256];
  bit          mk [4][256];

  systolic_2x2_engine dut (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
    .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] adr, input logic [15:0] d);
    ibus_wadr = adr; ibus_wdata = d; wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] adr, output logic [15:0] d);
    ibus_radr = adr; ren = 1'b1;
    @(posedge clk); #1;
    d = ibus_rdata; ren = 1'b0;
  endtask

  // b: 0=A0 1=A1 2=B0 3=B1
  task automatic wr_buf(input int b, input int n, input logic [15:0] v);
    logic [15:0] adr;
    adr = 16'h4000 + 16'(b * 512 + n);
    bus_write(adr, v);
    if (b < 2) ma[b][n] = v;
    else       mb[b-2][n] = v;
  endtask

  // OBUF index: 0=(0,0) 1=(1,0) 2=(0,1) 3=(1,1)
  task automatic model_job(input int k, input int r);
    logic [31:0] sum;
    int n;
    for (int rr = 0; rr < r; rr++) begin
      for (int idx = 0; idx < 4; idx++) begin
        sum = '0;
        for (int kk = 0; kk < k; kk++) begin
          n = (rr * k + kk) % 256;
          sum = sum + ({16'b0, ma[idx % 2][n]} * {16'b0, mb[idx / 2][n]});
        end
        mo[idx][rr % 256] = sum;
        mk[idx][rr % 256] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int nk, input int pre);
    logic [15:0] s;
    int cyc;
    bit done;
    cyc = pre;
    done = 1'b0;
    while (!done && cyc < nk + 40) begin
      bus_read(16'hFFF0, s);
      cyc++;
      if (pre == 0 && cyc == 1) check("busy_set", {31'b0, s[0]}, 32'd1);
      if (s[0] == 1'b0) done = 1'b1;
    end
    check("busy_lat", {31'b0, (done && cyc <= nk + 9)}, 32'd1);
  endtask

  task automatic run_job(input int k, input int r);
    bus_write(16'hFFF1, 16'(k - 1));
    bus_write(16'hFFF2, 16'(r - 1));
    bus_write(16'hFFF0, 16'h0001);
    wait_idle(k * r, 0);
    model_job(k, r);
  endtask

  task automatic obuf_rd(input int idx, input int e, input bit hi, output logic [15:0] d);
    bus_read(16'h8000 + 16'(idx * 512 + (hi ? 256 : 0) + e), d);
  endtask

  task automatic check_obufs(input string tag);
    logic [15:0] d;
    for (int idx = 0; idx < 4; idx++)
      for (int e = 0; e < 256; e++)
        if (mk[idx][e]) begin
          obuf_rd(idx, e, 1'b0, d);
          check({tag, "_lo"}, {16'b0, d}, {16'b0, mo[idx][e][15:0]});
          obuf_rd(idx, e, 1'b1, d);
          check({tag, "_hi"}, {16'b0, d}, {16'b0, mo[idx][e][31:16]});
        end
  endtask

  initial begin
    logic [15:0] d;
    int k, r;
    for (int i = 0; i < 4; i++)
      for (int e = 0; e < 256; e++) mk[i][e] = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state and register access
    bus_read(16'hFFF0, d); check("status_rst", {16'b0, d}, 32'h0);
    bus_read(16'hFFF1, d); check("max_rst", {16'b0, d}, 32'h0);
    bus_write(16'hFFF1, 16'd3);
    bus_write(16'hFFF2, 16'd3);
    bus_read(16'hFFF1, d); check("max_rb", {16'b0, d}, 32'h3);
    bus_read(16'hFFF2, d); check("run_rb", {16'b0, d}, 32'h3);
    ibus_radr = 16'hFFF0;
    @(posedge clk); #1;
    check("rdata_hold", {16'b0, ibus_rdata}, 32'h3);
    bus_read(16'h1234, d); check("unmapped", {16'b0, d}, 32'h0);

    // constant fill
    for (int n = 0; n < 16; n++) begin
      wr_buf(0, n, 16'd1); wr_buf(1, n, 16'd1);
      wr_buf(2, n, 16'd2); wr_buf(3, n, 16'd2);
    end
    bus_read(16'h4603, d); check("buf_rb", {16'b0, d}, 32'h2);
    run_job(4, 4);
    obuf_rd(3, 2, 1'b0, d); check("const_lo", {16'b0, d}, 32'h8);
    obuf_rd(3, 2, 1'b1, d); check("const_hi", {16'b0, d}, 32'h0);
    check_obufs("const");

    // ramp
    for (int n = 0; n < 16; n++) begin
      wr_buf(0, n, 16'(n + 1)); wr_buf(1, n, 16'd2);
      wr_buf(2, n, 16'd1);      wr_buf(3, n, 16'(n));
    end
    run_job(4, 4);
    obuf_rd(0, 1, 1'b0, d); check("ramp00", {16'b0, d}, 32'd26);
    obuf_rd(3, 3, 1'b0, d); check("ramp11", {16'b0, d}, 32'd108);
    check_obufs("ramp");

    // overflow: entries 1..3 keep the ramp results
    wr_buf(0, 0, 16'hFFFF); wr_buf(2, 0, 16'hFFFF);
    run_job(1, 1);
    obuf_rd(0, 0, 1'b0, d); check("ovf_lo", {16'b0, d}, 32'h0001);
    obuf_rd(0, 0, 1'b1, d); check("ovf_hi", {16'b0, d}, 32'hFFFE);
    check_obufs("ovf");

    // randomized jobs with address wrap
    for (int b = 0; b < 4; b++)
      for (int n = 0; n < 256; n++) wr_buf(b, n, 16'($urandom));
    for (int t = 0; t < 6; t++) begin
      for (int w = 0; w < 16; w++)
        wr_buf(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 16'($urandom));
      k = int'($urandom_range(1, 24));
      r = int'($urandom_range(1, 20));
      run_job(k, r);
      check_obufs("rand");
    end

    // busy protection
    bus_write(16'hFFF1, 16'd3);
    bus_write(16'hFFF2, 16'd3);
    bus_write(16'hFFF0, 16'h0001);
    bus_write(16'hFFF1, 16'd7);
    bus_write(16'hFFF0, 16'h0001);
    bus_write(16'h4002, 16'hBEEF);
    obuf_rd(0, 0, 1'b0, d);
    wait_idle(16, 4);
    model_job(4, 4);
    bus_read(16'hFFF1, d); check("max_locked", {16'b0, d}, 32'h3);
    bus_read(16'h4002, d); check("buf_locked", {16'b0, d}, {16'b0, ma[0][2]});
    check_obufs("busy");

    // reset mid-job
    bus_write(16'hFFF1, 16'd7);
    bus_write(16'hFFF2, 16'd7);
    bus_write(16'hFFF0, 16'h0001);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int e = 0; e < 256; e++) mk[i][e] = 1'b0;
    bus_read(16'hFFF0, d); check("status_abort", {16'b0, d}, 32'h0);
    bus_read(16'hFFF1, d); check("max_abort", {16'b0, d}, 32'h0);
    bus_read(16'hFFF2, d); check("run_abort", {16'b0, d}, 32'h0);
    run_job(3, 5);
    check_obufs("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_2x2_engine.md
Name: systolic_2x2_engine

Overview:
- 2x2 output-stationary systolic matrix-multiply engine with an internal 16-bit register/memory bus.
- Holds two A row-stream buffers (A0, A1) and two B column-stream buffers (B0, B1).
- Four PEs PE(i,j) accumulate A_i·B_j dot products; results go to four output buffers OBUF(i,j).
- Sits as a host-bus slave; the host loads operands, programs the counters, starts the engine, polls busy and reads results.

Parameters:
- DW, 16, operand and bus data width.
- IDEPTH_LG, 8, log2 depth of each A/B buffer (256 x 16-bit words).
- ODEPTH_LG, 8, log2 depth of each OBUF (256 x 32-bit words).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- ren  in  1  bus read enable.
- ibus_radr  in  16  read address.
- ibus_rdata  out  16  read data, registered.
- wen  in  1  bus write enable.
- ibus_wadr  in  16  write address.
- ibus_wdata  in  16  write data.

Behaviour:
- Address map: adr[15:9] selects a region, adr[8:0] is the offset.
  - Regions 0x20/0x21/0x22/0x23 are A0/A1/B0/B1; offset[7:0] is the word index; read/write.
  - Regions 0x40/0x41/0x42/0x43 are OBUF(0,0)/(1,0)/(0,1)/(1,1); read-only.
    - OBUF offset[8]=0 returns result[15:0] of entry offset[7:0].
    - OBUF offset[8]=1 returns result[31:16] of entry offset[7:0].
  - 0xFFF0 START/STATUS.
    - Write with wdata[0]=1 while idle starts a job.
    - Read returns {15'b0, busy}.
  - 0xFFF1 MAX_CNTR, read/write: K-1, the dot-product length minus 1.
  - 0xFFF2 RUN_CNTR, read/write: R-1, the number of runs minus 1.
  - Unmapped reads return 0; unmapped writes are ignored.
- Read timing: ibus_rdata is updated on the clk edge where ren=1, from ibus_radr sampled at that edge. It holds its value while ren=0.
- Write timing: a write takes effect on the clk edge where wen=1.
- Reset:
  - ibus_rdata=0, busy=0, MAX_CNTR=0, RUN_CNTR=0, all PE accumulators and skew registers cleared, FSM=IDLE.
  - Buffer RAM contents are not reset.
  - Reset mid-job aborts the job; no further OBUF writes occur.
- Job semantics, for run r in 0..R-1 and PE(i,j):
  - OBUF(i,j)[r] = sum over k=0..K-1 of A_i[r*K+k] * B_j[r*K+k].
  - Operands are unsigned 16-bit; products are 32-bit; the accumulator is 32-bit and wraps mod 2^32.
  - Buffer addresses wrap mod 256. OBUF entries >= R keep their prior contents.
- Systolic data flow:
  - A_i enters PE(i,0) and is forwarded one register stage to PE(i,1).
  - B_j enters PE(0,j) and is forwarded one stage to PE(1,j).
  - Row 1 and column 1 inputs are skewed by one cycle so matching k indices meet.
  - Each PE clears its accumulator at k=0 of every run.
  - Each PE writes its result to OBUF at the end of the run, after its skew delay.
- FSM:
  - IDLE → FEED on start.
  - FEED issues one buffer read per cycle for R*K cycles.
  - FEED → DRAIN after the last read.
  - DRAIN lasts a fixed 4 cycles, enough to flush the skew and the final writeback.
  - DRAIN → IDLE.
  - busy=1 in FEED and DRAIN.
  - busy must return to 0 no later than R*K+8 cycles after the start write.
- Simultaneous events and host-access limits:
  - Start writes while busy are ignored.
  - MAX/RUN writes while busy are ignored.
  - Host writes to A/B buffers while busy are ignored.
  - Host reads of OBUF while busy return undefined data but must not disturb the job.

Test Plan:
- Register access: write MAX_CNTR=3, RUN_CNTR=3, read both back → 0x0003 each. Read 0xFFF0 after reset → 0x0000.
- Constant fill: A0=A1=1, B0=B1=2 in words 0..15, K=4, R=4, start, poll busy until 0.
  - All OBUF entries 0..3 low half = 0x0008; offset 0x100 (high half) = 0x0000.
- Ramp: A0[n]=n+1, A1[n]=2, B0[n]=1, B1[n]=n, K=4, R=4.
  - OBUF(0,0)[0..3] = 10, 26, 42, 58.
  - OBUF(1,0)[0..3] = 8 each.
  - OBUF(1,1)[0..3] = 12, 44, 76, 108.
- Overflow: A0[0]=B0[0]=0xFFFF, K=1, R=1 → OBUF(0,0)[0]: low half 0x0001, high half 0xFFFE.
- Busy protection: start, then immediately rewrite MAX_CNTR=7 and issue a second start.
  - Results match the original K=4/R=4 job; busy deasserts within R*K+8 cycles.
- Reset mid-job: assert rst_n=0 during FEED, release → STATUS=0, MAX_CNTR=0; a new start then completes correctly.
